micro_io_wrapper: RTL and testbench



---
 rtl/micro_io_wrapper.sv | 239 +++++++++++++++++++++++
 tb/tb_micro_io_wrapper.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/micro_io_wrapper.sv
// Control-path processor subsystem: KCPSM6-compatible core, program ROM and the port glue
// (address decode, peripheral access strobes, read mux, interrupt flag).

// Subset of the KCPSM6 instruction set (LOAD kk, INPUT, OUTPUT, JUMP, ENABLE/DISABLE INTERRUPT)
// with the same port list and two-clock instruction timing.
module kcpsm6 (
  input  logic        clk,
  input  logic        reset,
  input  logic        sleep,
  input  logic        interrupt,
  input  logic [17:0] instruction,
  input  logic [7:0]  in_port,
  output logic [11:0] address,
  output logic        bram_enable,
  output logic [7:0]  port_id,
  output logic [7:0]  out_port,
  output logic        write_strobe,
  output logic        read_strobe,
  output logic        interrupt_ack
);
  localparam logic [5:0] OpLoad  = 6'h01;
  localparam logic [5:0] OpInput = 6'h09;
  localparam logic [5:0] OpJump  = 6'h22;
  localparam logic [5:0] OpEint  = 6'h28;
  localparam logic [5:0] OpOut   = 6'h2D;

  logic        phase_q, phase_d;
  logic [11:0] pc_q, pc_d;
  logic        int_en_q, int_en_d;
  logic [7:0]  rf_q [16];
  logic        rf_we;
  logic [7:0]  rf_wdata;

  logic [5:0] op;
  logic [3:0] sx;
  logic [7:0] kk;
  assign op = instruction[17:12];
  assign sx = instruction[11:8];
  assign kk = instruction[7:0];

  assign address      = pc_q;
  assign bram_enable  = phase_q & ~sleep;
  assign port_id      = kk;
  assign out_port     = rf_q[sx];
  assign write_strobe = phase_q & (op == OpOut);
  assign read_strobe  = phase_q & (op == OpInput);

  // Phase 0 decodes and picks the next fetch address; phase 1 strobes, writes back and fetches.
  always_comb begin
    phase_d       = phase_q;
    pc_d          = pc_q;
    int_en_d      = int_en_q;
    rf_we         = 1'b0;
    rf_wdata      = kk;
    interrupt_ack = 1'b0;
    if (!sleep) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        interrupt_ack = int_en_q & interrupt;
        if (interrupt_ack) begin
          pc_d     = 12'h3FF;
          int_en_d = 1'b0;
        end else if (op == OpJump) begin
          pc_d = instruction[11:0];
        end else begin
          pc_d = pc_q + 12'd1;
        end
      end else begin
        rf_we    = (op == OpLoad) | (op == OpInput);
        rf_wdata = (op == OpInput) ? in_port : kk;
        if (op == OpEint) int_en_d = instruction[0];
      end
    end
  end

  // Reset lands in phase 1 with a null instruction so the first fetch is from address 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= 1'b1;
      pc_q     <= '0;
      int_en_q <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      int_en_q <= int_en_d;
      if (rf_we) rf_q[sx] <= rf_wdata;
    end
  end
endmodule

// Program ROM: synchronous read, one word per enabled clock.
module micro_io_rom (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] address,
  output logic [17:0] instruction
);
  logic [17:0] instr_q, rom_d;

  always_comb begin
    rom_d = {6'h22, 12'h013};
    case (address)
      12'd0:  rom_d = {6'h01, 4'd0, 8'hA5};
      12'd1:  rom_d = {6'h2D, 4'd0, 8'h33};
      12'd2:  rom_d = {6'h09, 4'd1, 8'h05};
      12'd3:  rom_d = {6'h2D, 4'd1, 8'h80};
      12'd4:  rom_d = {6'h09, 4'd2, 8'h45};
      12'd5:  rom_d = {6'h2D, 4'd2, 8'h81};
      12'd6:  rom_d = {6'h09, 4'd3, 8'h25};
      12'd7:  rom_d = {6'h2D, 4'd3, 8'h82};
      12'd8:  rom_d = {6'h09, 4'd4, 8'h65};
      12'd9:  rom_d = {6'h2D, 4'd4, 8'h90};
      12'd10: rom_d = {6'h01, 4'd5, 8'h01};
      12'd11: rom_d = {6'h2D, 4'd5, 8'hFF};
      12'd12: rom_d = {6'h01, 4'd6, 8'h00};
      12'd13: rom_d = {6'h2D, 4'd6, 8'hFF};
      12'd14: rom_d = {6'h09, 4'd7, 8'hFF};
      12'd15: rom_d = {6'h2D, 4'd7, 8'h83};
      12'd16: rom_d = {6'h2D, 4'd5, 8'hFF};
      12'd17: rom_d = {6'h2D, 4'd5, 8'hFF};
      12'd18: rom_d = {6'h2D, 4'd0, 8'h33};
      default: ;
    endcase
  end

  assign instruction = instr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instr_q <= '0;
    else if (enable) instr_q <= rom_d;
  end
endmodule

module micro_io_wrapper (
  input  logic       clk,
  input  logic       kcpsm6_reset,
  input  logic [7:0] in_portRTC,
  input  logic [7:0] in_portteclado,
  input  logic [7:0] in_portVGA,
  input  logic       interrupt_ack,
  output logic [7:0] out_port,
  output logic [7:0] dir,
  output logic       writestrobe,
  output logic       read_strobe,
  output logic       interrupt,
  output logic       actRTC,
  output logic       actVGA,
  output logic       actTeclado,
  output logic       actsonido
);
  logic [1:0]  rst_q, rst_d;
  logic        rst_sync;
  logic [7:0]  in_port_q, in_port_d;
  logic        interrupt_q, interrupt_d;
  logic        core_ack;
  logic [11:0] address;
  logic [17:0] instruction;
  logic        bram_enable;

  // Assert immediately, release after two clean clock edges.
  assign rst_d    = {rst_q[0], 1'b0};
  assign rst_sync = rst_q[1];

  always_ff @(posedge clk or negedge kcpsm6_reset) begin
    if (!kcpsm6_reset) rst_q <= 2'b11;
    else rst_q <= rst_d;
  end

  kcpsm6 u_core (
    .clk           (clk),
    .reset         (rst_sync),
    .sleep         (1'b0),
    .interrupt     (interrupt_q),
    .instruction   (instruction),
    .in_port       (in_port_q),
    .address       (address),
    .bram_enable   (bram_enable),
    .port_id       (dir),
    .out_port      (out_port),
    .write_strobe  (writestrobe),
    .read_strobe   (read_strobe),
    .interrupt_ack (core_ack)
  );

  micro_io_rom u_rom (
    .clk         (clk),
    .reset       (rst_sync),
    .enable      (bram_enable),
    .address     (address),
    .instruction (instruction)
  );

  always_comb begin
    actRTC     = 1'b0;
    actVGA     = 1'b0;
    actTeclado = 1'b0;
    actsonido  = 1'b0;
    if (writestrobe | read_strobe) begin
      case (dir[7:5])
        3'd0:    actRTC     = 1'b1;
        3'd1:    actVGA     = 1'b1;
        3'd2:    actTeclado = 1'b1;
        3'd3:    actsonido  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_port_d = 8'h00;
    if (dir == 8'hFF) begin
      in_port_d = {7'b0, interrupt_q};
    end else begin
      case (dir[7:5])
        3'd0:    in_port_d = in_portRTC;
        3'd1:    in_port_d = in_portVGA;
        3'd2:    in_port_d = in_portteclado;
        default: in_port_d = 8'h00;
      endcase
    end
  end

  // Acknowledge beats a same-cycle set.
  assign interrupt_d = (interrupt_q | (writestrobe & (dir == 8'hFF) & out_port[0]))
                       & ~(interrupt_ack | core_ack);
  assign interrupt   = interrupt_q;

  always_ff @(posedge clk or negedge kcpsm6_reset) begin
    if (!kcpsm6_reset) begin
      in_port_q   <= 8'h00;
      interrupt_q <= 1'b0;
    end else begin
      in_port_q   <= in_port_d;
      interrupt_q <= interrupt_d;
    end
  end
endmodule

// File: tb/tb_micro_io_wrapper.sv
// Directed bench: follows the built-in ROM program and checks strobes, read data and interrupt.
module tb_micro_io_wrapper;
  logic       clk = 1'b0;
  logic       kcpsm6_reset = 1'b0;
  logic [7:0] in_portRTC = 8'h11;
  logic [7:0] in_portteclado = 8'h22;
  logic [7:0] in_portVGA = 8'h33;
  logic       interrupt_ack = 1'b0;
  logic [7:0] out_port, dir;
  logic       writestrobe, read_strobe, interrupt;
  logic       actRTC, actVGA, actTeclado, actsonido;
  logic [3:0] acts;

  int checks = 0;
  int errors = 0;

  micro_io_wrapper dut (
    .clk            (clk),
    .kcpsm6_reset   (kcpsm6_reset),
    .in_portRTC     (in_portRTC),
    .in_portteclado (in_portteclado),
    .in_portVGA     (in_portVGA),
    .interrupt_ack  (interrupt_ack),
    .out_port       (out_port),
    .dir            (dir),
    .writestrobe    (writestrobe),
    .read_strobe    (read_strobe),
    .interrupt      (interrupt),
    .actRTC         (actRTC),
    .actVGA         (actVGA),
    .actTeclado     (actTeclado),
    .actsonido      (actsonido)
  );

  always #5 clk = ~clk;

  assign acts = {actRTC, actVGA, actTeclado, actsonido};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge inside the matching strobe cycle.
  task automatic wait_io(input logic wr, input logic [7:0] port, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (wr ? writestrobe : read_strobe) && (dir == port);
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL %s: observed no strobe to port %02h, expected one within 200 cycles", tag, port);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_acts", {4'b0, acts}, 8'h00);
    check("rst_wstrobe", {7'b0, writestrobe}, 8'h00);
    check("rst_rstrobe", {7'b0, read_strobe}, 8'h00);
    check("rst_interrupt", {7'b0, interrupt}, 8'h00);
    check("rst_in_port", dut.in_port_q, 8'h00);
    repeat (7) @(negedge clk);
    kcpsm6_reset = 1'b1;

    wait_io(1'b1, 8'h33, "out33");
    check("out33_dir", dir, 8'd51);
    check("out33_data", out_port, 8'hA5);
    check("out33_acts", {4'b0, acts}, 8'b0100);
    check("out33_int", {7'b0, interrupt}, 8'h00);
    @(negedge clk);
    check("out33_wfall", {7'b0, writestrobe}, 8'h00);
    check("out33_afall", {4'b0, acts}, 8'h00);

    wait_io(1'b0, 8'h05, "in05");
    check("in05_acts", {4'b0, acts}, 8'b1000);
    wait_io(1'b1, 8'h80, "echo80");
    check("echo80_data", out_port, 8'h11);
    check("echo80_acts", {4'b0, acts}, 8'h00);

    wait_io(1'b0, 8'h45, "in45");
    check("in45_acts", {4'b0, acts}, 8'b0010);
    wait_io(1'b1, 8'h81, "echo81");
    check("echo81_data", out_port, 8'h22);

    wait_io(1'b0, 8'h25, "in25");
    check("in25_acts", {4'b0, acts}, 8'b0100);
    wait_io(1'b1, 8'h82, "echo82");
    check("echo82_data", out_port, 8'h33);

    wait_io(1'b0, 8'h65, "in65");
    check("in65_acts", {4'b0, acts}, 8'b0001);
    wait_io(1'b1, 8'h90, "out90");
    check("out90_data", out_port, 8'h00);
    check("out90_acts", {4'b0, acts}, 8'h00);

    wait_io(1'b1, 8'hFF, "irq_set");
    check("irq_set_acts", {4'b0, acts}, 8'h00);
    check("irq_before", {7'b0, interrupt}, 8'h00);
    @(negedge clk);
    check("irq_after", {7'b0, interrupt}, 8'h01);

    wait_io(1'b1, 8'hFF, "irq_bit0_zero");
    check("irq_b0z_data", out_port, 8'h00);
    @(negedge clk);
    check("irq_b0z_hold", {7'b0, interrupt}, 8'h01);

    wait_io(1'b0, 8'hFF, "in_ff");
    wait_io(1'b1, 8'h83, "echo83");
    check("echo83_data", out_port, 8'h01);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("irq_ack", {7'b0, interrupt}, 8'h00);

    wait_io(1'b1, 8'hFF, "irq_both");
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("irq_both", {7'b0, interrupt}, 8'h00);

    wait_io(1'b1, 8'hFF, "irq_reset");
    @(negedge clk);
    check("irq_reset_pre", {7'b0, interrupt}, 8'h01);

    wait_io(1'b1, 8'h33, "mid_out");
    #1 kcpsm6_reset = 1'b0;
    #1;
    check("mid_wstrobe", {7'b0, writestrobe}, 8'h00);
    check("mid_acts", {4'b0, acts}, 8'h00);
    check("mid_interrupt", {7'b0, interrupt}, 8'h00);
    repeat (4) @(negedge clk);
    kcpsm6_reset = 1'b1;

    wait_io(1'b1, 8'h33, "restart_out");
    check("restart_data", out_port, 8'hA5);
    wait_io(1'b0, 8'h05, "restart_in");
    check("restart_acts", {4'b0, acts}, 8'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
